adc_capture_ctrl: RTL

Single-clock ADC sample capture controller for the ADC test bench.
- Takes already-synchronised ADC codes tagged with a channel number and filters them by channel mask and decimation ratio.
- Sequences capture in continuous, immediate-burst or triggered-burst mode.
- Buffers accepted samples in an internal FIFO that the readout logic drains over a valid/ready handshake.
- Generalises the fixed 10-bit, single-channel, always-write capture path to parametrised width, depth and channel count, and adds overflow accounting.

---
 rtl/adc_capture_pkg.sv | 28 ++
 rtl/adc_sample_fifo.sv | 63 ++++++
 rtl/adc_capture_ctrl.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/adc_capture_pkg.sv
// Shared encodings and elaboration helpers for the ADC capture controller.
// Imported by the capture control top and its sample FIFO.
package adc_capture_pkg;

  typedef enum logic [1:0] {
    MODE_CONT  = 2'd0,
    MODE_BURST = 2'd1,
    MODE_TRIG  = 2'd2,
    MODE_RSVD  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_TRIG = 2'd1,
    ST_CAPTURE   = 2'd2
  } state_e;

  // Ceiling log2; clog2(1) is 0, so callers clamp widths to at least 1 bit.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/adc_sample_fifo.sv
// Single-clock first-word-fall-through FIFO holding {channel, code} samples.
// The head reads as zero while empty so the outputs are clean after reset.
module adc_sample_fifo
  import adc_capture_pkg::*;
#(
  parameter int WIDTH   = 12,
  parameter int DEPTH   = 1024,
  parameter int COUNT_W = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic [WIDTH-1:0]   wr_data,
  input  logic               pop,
  output logic [WIDTH-1:0]   rd_data,
  output logic               full,
  output logic               empty,
  output logic [COUNT_W-1:0] count
);

  localparam int AW = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);
  localparam logic [COUNT_W-1:0] DEPTH_C = COUNT_W'(DEPTH);

  logic [WIDTH-1:0]   mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [COUNT_W-1:0] count_q;
  logic               do_push;
  logic               do_pop;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A push at full is only taken when the head leaves in the same cycle.
  assign empty   = (count_q == '0);
  assign full    = (count_q == DEPTH_C);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = empty ? '0 : mem[rd_ptr];
  assign count   = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/adc_capture_ctrl.sv
// ADC capture controller: channel mask, decimation and burst/trigger sequencing
// in front of a FWFT sample FIFO drained over a valid/ready handshake.
module adc_capture_ctrl
  import adc_capture_pkg::*;
#(
  parameter  int PRECISION        = 10,
  parameter  int NUM_CH           = 1,
  parameter  int DEPTH            = 1024,
  parameter  int FIFO_COUNT_WIDTH = 12,
  parameter  int DECIM_WIDTH      = 8,
  localparam int CH_W             = (clog2(NUM_CH) < 1) ? 1 : clog2(NUM_CH)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        sample_valid,
  input  logic [PRECISION-1:0]        sample_code,
  input  logic [CH_W-1:0]             sample_ch,
  input  logic [1:0]                  mode,
  input  logic                        arm,
  input  logic                        abort,
  input  logic                        trigger,
  input  logic [FIFO_COUNT_WIDTH-1:0] burst_len,
  input  logic [DECIM_WIDTH-1:0]      decim,
  input  logic [NUM_CH-1:0]           ch_mask,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [PRECISION-1:0]        out_code,
  output logic [CH_W-1:0]             out_ch,
  output logic [FIFO_COUNT_WIDTH-1:0] count,
  output logic [1:0]                  state,
  output logic                        overflow,
  output logic                        done
);

  localparam int MASK_W = 1 << CH_W;

  state_e                      state_q, state_d;
  mode_e                       mode_q;
  logic [FIFO_COUNT_WIDTH-1:0] blen_q;
  logic [FIFO_COUNT_WIDTH-1:0] bcnt_q;
  logic [DECIM_WIDTH-1:0]      decim_q;
  logic [DECIM_WIDTH-1:0]      dcnt_q;
  logic [NUM_CH-1:0]           mask_q;
  logic [MASK_W-1:0]           mask_ext;
  logic                        trig_q;
  logic                        overflow_q;
  logic                        done_q, done_d;
  logic                        arm_go, trig_rise, eligible, accept;
  logic                        pop, push, burst_end;
  logic                        fifo_full, fifo_empty;
  logic [PRECISION+CH_W-1:0]   rd_data;

  // Padding the mask to every encodable tag makes out-of-range channels ineligible.
  always_comb begin
    mask_ext = '0;
    mask_ext[NUM_CH-1:0] = mask_q;
  end

  assign arm_go    = arm && !abort && (state_q == ST_IDLE);
  assign trig_rise = trigger && !trig_q;
  assign eligible  = sample_valid && (state_q == ST_CAPTURE) && mask_ext[sample_ch];
  assign accept    = eligible && (dcnt_q == '0);
  assign pop       = out_valid && out_ready;
  assign push      = accept && (!fifo_full || pop);
  assign burst_end = accept && (mode_q != MODE_CONT) && ((bcnt_q + 1'b1) == blen_q);

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arm_go) state_d = (mode == MODE_TRIG) ? ST_WAIT_TRIG : ST_CAPTURE;
      end
      ST_WAIT_TRIG: begin
        if (abort)          state_d = ST_IDLE;
        else if (trig_rise) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (burst_end) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      trig_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      trig_q  <= trigger;
      done_q  <= done_d;
    end
  end

  // Configuration is frozen at arm; a zero burst length behaves as one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q     <= MODE_CONT;
      blen_q     <= FIFO_COUNT_WIDTH'(1);
      decim_q    <= '0;
      mask_q     <= '0;
      dcnt_q     <= '0;
      bcnt_q     <= '0;
      overflow_q <= 1'b0;
    end else if (arm_go) begin
      mode_q     <= mode_e'(mode);
      blen_q     <= (burst_len == '0) ? FIFO_COUNT_WIDTH'(1) : burst_len;
      decim_q    <= decim;
      mask_q     <= ch_mask;
      dcnt_q     <= '0;
      bcnt_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (eligible)          dcnt_q     <= (dcnt_q == decim_q) ? '0 : dcnt_q + 1'b1;
      if (accept)            bcnt_q     <= bcnt_q + 1'b1;
      if (accept && !push)   overflow_q <= 1'b1;
    end
  end

  adc_sample_fifo #(
    .WIDTH   (PRECISION + CH_W),
    .DEPTH   (DEPTH),
    .COUNT_W (FIFO_COUNT_WIDTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .wr_data ({sample_ch, sample_code}),
    .pop     (pop),
    .rd_data (rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (count)
  );

  assign out_valid          = !fifo_empty;
  assign {out_ch, out_code} = rd_data;
  assign state              = state_q;
  assign overflow           = overflow_q;
  assign done               = done_q;

endmodule
